// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU load/store, DMA/debug) for the single-port 32x64 data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed CPU priority.
module dmem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic          cpu_req_write,
    input  logic [AW-1:0] cpu_req_addr,
    input  logic [DW-1:0] cpu_req_wdata,
    output logic          cpu_rsp_valid,
    output logic [DW-1:0] cpu_rsp_rdata,

    input  logic          dma_req_valid,
    output logic          dma_req_ready,
    input  logic          dma_req_write,
    input  logic [AW-1:0] dma_req_addr,
    input  logic [DW-1:0] dma_req_wdata,
    output logic          dma_rsp_valid,
    output logic [DW-1:0] dma_rsp_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;          // 0 = CPU, 1 = DMA
    logic   dma_wins_tie;
    logic   gnt_cpu;
    logic   gnt_dma;
    logic   hs;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_dma;         // most recent grant went to the DMA port

    assign dma_wins_tie = ~last_dma;
`else
    assign dma_wins_tie = 1'b0;
`endif

    assign gnt_cpu = cpu_req_valid & ~(dma_req_valid & dma_wins_tie);
    assign gnt_dma = dma_req_valid & ~gnt_cpu;

    // Ready is gated by rst_n so nothing is granted while reset is held.
    assign cpu_req_ready = rst_n & (state == IDLE) & gnt_cpu;
    assign dma_req_ready = rst_n & (state == IDLE) & gnt_dma;
    assign hs            = cpu_req_ready | dma_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            dma_rsp_valid <= 1'b0;
            cpu_rsp_rdata <= '0;
            dma_rsp_rdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_dma      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (hs) begin
                        state     <= ACCESS;
                        owner     <= gnt_dma;
                        mem_addr  <= gnt_dma ? dma_req_addr  : cpu_req_addr;
                        mem_wdata <= gnt_dma ? dma_req_wdata : cpu_req_wdata;
                        mem_write <= gnt_dma ? dma_req_write  : cpu_req_write;
                        mem_read  <= gnt_dma ? ~dma_req_write : ~cpu_req_write;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_dma  <= gnt_dma;
`endif
                    end
                end
                ACCESS: begin
                    // The rising edge of mem_read at ACCESS entry refreshed mem_rdata.
                    if (mem_read) begin
                        if (owner) dma_rsp_rdata <= mem_rdata;
                        else       cpu_rsp_rdata <= mem_rdata;
                    end
                    mem_read      <= 1'b0;
                    mem_write     <= 1'b0;
                    cpu_rsp_valid <= ~owner;
                    dma_rsp_valid <= owner;
                    state         <= RESP;
                end
                RESP: begin
                    cpu_rsp_valid <= 1'b0;
                    dma_rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    mem_read      <= 1'b0;
                    mem_write     <= 1'b0;
                    cpu_rsp_valid <= 1'b0;
                    dma_rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: randomized two-port traffic against a word-array memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_write = 1'b0;
    logic [63:0] cpu_req_addr = '0, cpu_req_wdata = '0, cpu_rsp_rdata;
    logic        cpu_rsp_valid;
    logic        dma_req_valid = 1'b0, dma_req_ready, dma_req_write = 1'b0;
    logic [63:0] dma_req_addr = '0, dma_req_wdata = '0, dma_rsp_rdata;
    logic        dma_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    dmem_arbiter #(.AW(64), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_rdata(cpu_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_write(dma_req_write), .dma_req_addr(dma_req_addr),
        .dma_req_wdata(dma_req_wdata), .dma_rsp_valid(dma_rsp_valid),
        .dma_rsp_rdata(dma_rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory device: writes on the clock, ReadData refreshed only on a MemRead rising edge.
    logic [63:0] dev_mem [32];
    always @(posedge clk) if (mem_write) dev_mem[mem_addr[4:0]] <= mem_wdata;
    always @(posedge mem_read) mem_rdata <= dev_mem[mem_addr[4:0]];

    typedef struct { logic wr; logic [63:0] addr; logic [63:0] wd; } req_t;
    typedef struct { logic port; logic [63:0] rd; int cyc; } exp_t;

    int   tests = 0, fails = 0, cyc = 0;
    exp_t exp_q[$];
    req_t pend_c[$], pend_d[$];
    int   grants[$], hs_cyc[$];
    int   last_hs = -100;
    logic cpu_on = 1'b0, dma_on = 1'b0, force_on = 1'b0;
    logic [63:0] mdl [32];
    logic [63:0] last_rd [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response pulse is visible.
    logic        prev_mr = 1'b0, prev_mw = 1'b0;
    logic [63:0] prev_crd = '0, prev_drd = '0;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read)  check("mem_read_single_cycle", 64'(prev_mr), 64'd0);
            if (mem_write) check("mem_write_single_cycle", 64'(prev_mw), 64'd0);
            if (cpu_req_ready || dma_req_ready)
                check("one_ready_only", 64'(cpu_req_ready & dma_req_ready), 64'd0);
            if (!cpu_rsp_valid) check("cpu_rdata_hold", cpu_rsp_rdata, prev_crd);
            if (!dma_rsp_valid) check("dma_rdata_hold", dma_rsp_rdata, prev_drd);
            if (cpu_rsp_valid || dma_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: cpu=%b dma=%b with empty scoreboard", cpu_rsp_valid, dma_rsp_valid);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_owner", {62'd0, cpu_rsp_valid, dma_rsp_valid}, mon_e.port ? 64'd1 : 64'd2);
                    check("rsp_rdata", mon_e.port ? dma_rsp_rdata : cpu_rsp_rdata, mon_e.rd);
                    check("rsp_latency", 64'(cyc - mon_e.cyc), 64'd2);
                end
            end
        end
        prev_mr  <= mem_read;
        prev_mw  <= mem_write;
        prev_crd <= cpu_rsp_rdata;
        prev_drd <= dma_rsp_rdata;
    end

    // Reference: accesses complete in handshake order against a flat 32-word array.
    task automatic accept(input logic port, input req_t r);
        exp_t e;
        check("hs_spacing_ge3", 64'((cyc - last_hs) >= 3), 64'd1);
        last_hs = cyc;
        hs_cyc.push_back(cyc);
        grants.push_back(int'(port));
        if (r.wr) mdl[r.addr[4:0]] = r.wd;
        else      last_rd[port] = mdl[r.addr[4:0]];
        e.port = port; e.rd = last_rd[port]; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic present();
        if (!cpu_on && pend_c.size() > 0) cpu_on = force_on || ($urandom_range(0, 3) != 0);
        if (!dma_on && pend_d.size() > 0) dma_on = force_on || ($urandom_range(0, 3) != 0);
        cpu_req_valid = cpu_on;
        dma_req_valid = dma_on;
        if (cpu_on) begin
            cpu_req_write = pend_c[0].wr; cpu_req_addr = pend_c[0].addr; cpu_req_wdata = pend_c[0].wd;
        end else begin
            cpu_req_addr = {$urandom, $urandom};
        end
        if (dma_on) begin
            dma_req_write = pend_d[0].wr; dma_req_addr = pend_d[0].addr; dma_req_wdata = pend_d[0].wd;
        end else begin
            dma_req_addr = {$urandom, $urandom};
        end
    endtask

    // n_grants == 0: drain everything; otherwise stop right after n more handshakes.
    task automatic run(input int budget, input int n_grants);
        int  target;
        int  n;
        logic hc, hd;
        target = grants.size() + n_grants;
        n = 0;
        while (n < budget && ((n_grants > 0) ? (grants.size() < target)
               : (pend_c.size() > 0 || pend_d.size() > 0 || exp_q.size() > 0 || cpu_on || dma_on))) begin
            @(negedge clk);
            hc = cpu_req_valid && cpu_req_ready;
            hd = dma_req_valid && dma_req_ready;
            if (hc) begin accept(1'b0, pend_c.pop_front()); cpu_on = 1'b0; end
            if (hd) begin accept(1'b1, pend_d.pop_front()); dma_on = 1'b0; end
            @(posedge clk); #1;
            present();
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL run_timeout: budget %0d cycles expired", budget);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] save_c;
        int          exp_g [4];
        last_rd[0] = '0; last_rd[1] = '0;
        cpu_req_valid = 1'b1; dma_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 64'(cpu_req_ready), 64'd0);
        check("rst_dma_ready", 64'(dma_req_ready), 64'd0);
        check("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        check("rst_rsp_valid", {62'd0, cpu_rsp_valid, dma_rsp_valid}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_cpu_rdata", cpu_rsp_rdata, 64'd0);
        check("rst_dma_rdata", dma_rsp_rdata, 64'd0);
        cpu_req_valid = 1'b0; dma_req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous contention straight after reset.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            pend_c.push_back('{1'b1, 64'(i), 64'hC000 + 64'(i)});
            pend_d.push_back('{1'b1, 64'(8 + i), 64'hD000 + 64'(i)});
        end
        force_on = 1'b1;
        present();
        run(100, 4);
        for (int i = 0; i < 4; i++) check("arb_grant_order", 64'(grants[i]), 64'(exp_g[i]));
        run(200, 0);

        // Preload every word so later reads are defined.
        for (int i = 0; i < 32; i++) pend_d.push_back('{1'b1, 64'(i), {$urandom, $urandom}});
        present();
        run(500, 0);

        // DMA write, then aliased CPU read.
        pend_d.push_back('{1'b1, 64'h3, 64'hDEAD_BEEF_0000_0001});
        present(); run(50, 0);
        pend_c.push_back('{1'b0, 64'h23, 64'h0});
        present(); run(50, 0);
        check("alias_read_data", cpu_rsp_rdata, 64'hDEAD_BEEF_0000_0001);

        // Back-to-back CPU reads.
        pend_d.push_back('{1'b1, 64'h1, 64'h11});
        pend_d.push_back('{1'b1, 64'h2, 64'h22});
        present(); run(50, 0);
        hs_cyc.delete();
        pend_c.push_back('{1'b0, 64'h1, 64'h0});
        pend_c.push_back('{1'b0, 64'h2, 64'h0});
        present(); run(50, 0);
        check("b2b_hs_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
        check("b2b_last_rdata", cpu_rsp_rdata, 64'h22);

        // CPU raises valid during a DMA ACCESS cycle.
        hs_cyc.delete();
        pend_d.push_back('{1'b0, 64'h5, 64'h0});
        present(); run(50, 1);
        pend_c.push_back('{1'b0, 64'h6, 64'h0});
        present();
        check("busy_cpu_ready", 64'(cpu_req_ready), 64'd0);
        run(50, 0);
        check("busy_grant_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
        check("busy_grant_port", 64'(grants[grants.size() - 1]), 64'd0);

        // CPU write then DMA read of the same word.
        pend_c.push_back('{1'b1, 64'h1F, 64'h5A5A});
        present(); run(50, 0);
        save_c = cpu_rsp_rdata;
        pend_d.push_back('{1'b0, 64'h1F, 64'h0});
        present(); run(50, 0);
        check("dma_read_after_cpu_write", dma_rsp_rdata, 64'h5A5A);
        check("cpu_rdata_untouched", cpu_rsp_rdata, save_c);

        // Randomized mixed traffic.
        force_on = 1'b0;
        for (int i = 0; i < 80; i++) begin
            req_t r;
            r.wr = 1'($urandom_range(0, 1));
            r.addr = {$urandom, $urandom};
            r.wd = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) pend_c.push_back(r);
            else                           pend_d.push_back(r);
        end
        present();
        run(3000, 0);
        check("final_cpu_rdata_model", cpu_rsp_rdata, last_rd[0]);
        check("final_dma_rdata_model", dma_rsp_rdata, last_rd[1]);

        // Reset during the ACCESS cycle of a write.
        force_on = 1'b1;
        pend_c.push_back('{1'b1, 64'h7, 64'hBAD0_BAD0});
        present(); run(50, 1);
        check("abort_write_active", 64'(mem_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_write", 64'(mem_write), 64'd0);
        check("abort_mem_read", 64'(mem_read), 64'd0);
        check("abort_rsp_valid", {62'd0, cpu_rsp_valid, dma_rsp_valid}, 64'd0);
        exp_q.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        cpu_on = 1'b0; dma_on = 1'b0;
        cpu_req_valid = 1'b0; dma_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_mem_addr_cleared", mem_addr, 64'd0);
        rst_n = 1'b1;
        last_hs = -100;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        pend_c.push_back('{1'b1, 64'h7, 64'h7777});
        pend_c.push_back('{1'b0, 64'h7, 64'h0});
        present(); run(50, 0);
        check("post_reset_read", cpu_rsp_rdata, 64'h7777);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
